// File: rtl/difftest_mc_endpoint.sv
// Multi-core difftest endpoint: aggregates per-core steps, exits and UART bytes
// into one sticky run verdict, with watchdogs, warmup/perf pulses and a merged UART stream.
module difftest_mc_endpoint #(
  parameter int NUM_CORES   = 2,
  parameter int STEP_WIDTH  = 8,
  parameter int STUCK_WIDTH = 32,
  parameter int UART_DEPTH  = 16,
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [63:0]                     cfg_max_cycles,
  input  logic [63:0]                     cfg_max_instrs,
  input  logic [63:0]                     cfg_warmup_instr,
  input  logic [STUCK_WIDTH-1:0]          cfg_stuck_limit,
  input  logic [NUM_CORES*STEP_WIDTH-1:0] core_step,
  input  logic [NUM_CORES*64-1:0]         core_exit,
  input  logic [NUM_CORES-1:0]            uart_in_valid,
  input  logic [NUM_CORES*8-1:0]          uart_in_ch,
  output logic [NUM_CORES-1:0]            uart_in_ready,
  output logic                            uart_out_valid,
  output logic [7:0]                      uart_out_ch,
  output logic [CW-1:0]                   uart_out_core,
  input  logic                            uart_out_ready,
  output logic [63:0]                     n_cycles,
  output logic                            status_valid,
  output logic [7:0]                      status_code,
  output logic [CW-1:0]                   status_core,
  output logic [63:0]                     status_cycle,
  output logic                            perf_clean,
  output logic                            perf_dump,
  output logic [1:0]                      dbg_state
);

  localparam int AW = $clog2(UART_DEPTH);

  localparam logic [7:0] CODE_GOOD   = 8'd1;
  localparam logic [7:0] CODE_EXCEED = 8'd2;
  localparam logic [7:0] CODE_FAIL   = 8'd3;
  localparam logic [7:0] CODE_STUCK  = 8'd5;
  localparam logic [7:0] CODE_MAXCYC = 8'd6;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state;

  logic [STEP_WIDTH-1:0]  step_s    [NUM_CORES];
  logic [63:0]            exit_s    [NUM_CORES];
  logic [7:0]             ch_s      [NUM_CORES];
  logic [63:0]            instr_cnt [NUM_CORES];
  logic [63:0]            instr_nxt [NUM_CORES];
  logic [STUCK_WIDTH-1:0] stuck_cnt [NUM_CORES];
  logic [NUM_CORES-1:0]   done_q;
  logic [NUM_CORES-1:0]   fail_q;
  logic                   warm_fired;

  logic          v_fire;
  logic [7:0]    v_code;
  logic [CW-1:0] v_core;
  logic          fail_hit, stuck_hit, exceed_hit;
  logic [CW-1:0] fail_idx, stuck_idx, exceed_idx;
  logic          warm_hit;

  assign dbg_state = state;

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      step_s[i]    = core_step[i*STEP_WIDTH +: STEP_WIDTH];
      exit_s[i]    = core_exit[i*64 +: 64];
      ch_s[i]      = uart_in_ch[i*8 +: 8];
      // Saturate rather than wrap so a runaway core still trips EXCEED.
      instr_nxt[i] = (instr_cnt[i] > ~64'(step_s[i])) ? '1 : instr_cnt[i] + 64'(step_s[i]);
    end
  end

  // Verdict reduction on registered state; descending scan leaves the lowest index.
  always_comb begin
    fail_hit   = 1'b0;
    stuck_hit  = 1'b0;
    exceed_hit = 1'b0;
    fail_idx   = '0;
    stuck_idx  = '0;
    exceed_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (fail_q[i]) begin
        fail_hit = 1'b1;
        fail_idx = CW'(i);
      end
      if (cfg_stuck_limit != '0 && stuck_cnt[i] >= cfg_stuck_limit) begin
        stuck_hit = 1'b1;
        stuck_idx = CW'(i);
      end
      if (cfg_max_instrs != '0 && instr_cnt[i] >= cfg_max_instrs) begin
        exceed_hit = 1'b1;
        exceed_idx = CW'(i);
      end
    end
    v_fire = 1'b0;
    v_code = '0;
    v_core = '0;
    if (state == ST_RUN) begin
      if (fail_hit) begin
        v_fire = 1'b1; v_code = CODE_FAIL;   v_core = fail_idx;
      end else if (stuck_hit) begin
        v_fire = 1'b1; v_code = CODE_STUCK;  v_core = stuck_idx;
      end else if (&done_q) begin
        v_fire = 1'b1; v_code = CODE_GOOD;
      end else if (exceed_hit) begin
        v_fire = 1'b1; v_code = CODE_EXCEED; v_core = exceed_idx;
      end else if (cfg_max_cycles != '0 && n_cycles >= cfg_max_cycles) begin
        v_fire = 1'b1; v_code = CODE_MAXCYC;
      end
    end
    warm_hit = (state == ST_RUN) && !v_fire && !warm_fired &&
               (cfg_warmup_instr != '0) && (instr_cnt[0] >= cfg_warmup_instr);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_INIT;
      n_cycles     <= '0;
      status_valid <= 1'b0;
      status_code  <= '0;
      status_core  <= '0;
      status_cycle <= '0;
      perf_clean   <= 1'b0;
      perf_dump    <= 1'b0;
      warm_fired   <= 1'b0;
      done_q       <= '0;
      fail_q       <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        instr_cnt[i] <= '0;
        stuck_cnt[i] <= '0;
      end
    end else begin
      perf_clean <= 1'b0;
      perf_dump  <= 1'b0;
      case (state)
        ST_INIT: state <= ST_RUN;
        ST_RUN: begin
          if (v_fire) begin
            // Counters freeze on the verdict edge so n_cycles stays equal to status_cycle.
            status_valid <= 1'b1;
            status_code  <= v_code;
            status_core  <= v_core;
            status_cycle <= n_cycles;
            perf_dump    <= 1'b1;
            state        <= ST_DONE;
          end else begin
            n_cycles <= n_cycles + 64'd1;
            if (warm_hit) begin
              perf_clean <= 1'b1;
              warm_fired <= 1'b1;
            end
            for (int i = 0; i < NUM_CORES; i++) begin
              instr_cnt[i] <= instr_nxt[i];
              if (&exit_s[i]) done_q[i] <= 1'b1;
              fail_q[i] <= (exit_s[i] != '0) && !(&exit_s[i]);
              if (!done_q[i]) begin
                if (step_s[i] != '0)   stuck_cnt[i] <= '0;
                else if (!(&stuck_cnt[i])) stuck_cnt[i] <= stuck_cnt[i] + 1'b1;
              end
            end
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_INIT;
      endcase
    end
  end

  // UART handshake: a byte moves at an edge where valid && ready. Sources hold valid
  // and data until accepted; uart_in_ready depends combinationally on uart_in_valid
  // and uart_out_ready, so a full FIFO can still accept when its head leaves this cycle.
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [CW+7:0]    mem [UART_DEPTH];
  logic [CW-1:0]    rr_ptr;
  logic             fifo_empty, fifo_full, mem_pop, can_push;
  logic             gnt_any;
  logic [CW-1:0]    gnt_idx;
  logic [NUM_CORES-1:0] grant;

  assign fifo_empty    = (wr_ptr == rd_ptr);
  assign fifo_full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign mem_pop       = !fifo_empty && (!uart_out_valid || uart_out_ready);
  assign can_push      = (state != ST_INIT) && (!fifo_full || mem_pop);
  assign uart_in_ready = grant;

  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int off = 0; off < NUM_CORES; off++) begin
      int idx;
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (can_push && !gnt_any && uart_in_valid[idx]) begin
        gnt_any    = 1'b1;
        gnt_idx    = CW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (gnt_any) mem[wr_ptr[AW-1:0]] <= {gnt_idx, ch_s[gnt_idx]};
  end

  // The output register is fed only from the FIFO head; an empty FIFO is never bypassed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rr_ptr         <= '0;
      uart_out_valid <= 1'b0;
      uart_out_ch    <= '0;
      uart_out_core  <= '0;
    end else begin
      if (gnt_any) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (int'(gnt_idx) == NUM_CORES - 1) ? '0 : gnt_idx + 1'b1;
      end
      if (mem_pop) begin
        rd_ptr         <= rd_ptr + 1'b1;
        uart_out_valid <= 1'b1;
        uart_out_ch    <= mem[rd_ptr[AW-1:0]][7:0];
        uart_out_core  <= mem[rd_ptr[AW-1:0]][CW+7:8];
      end else if (uart_out_valid && uart_out_ready) begin
        uart_out_valid <= 1'b0;
      end
    end
  end

endmodule
